config_responder: RTL and testbench
===================================

Name: config_responder

Overview:
- Command endpoint at the far end of the UDP configuration path.
- Consumes 32-bit words from the packet receiver (data_out_en/data_out) and executes register writes and reads on a simple register port.
- Queues two-word replies and hands them to the packet sender's primary interface as fixed-size packets; partial packets are padded after a timeout.

Parameters:
- PKT_WORDS, 128, words per reply packet; must be even and 2..256.
- FIFO_AW, 9, reply FIFO address width (depth 2**FIFO_AW, must be >= 2*PKT_WORDS).
- IN_AW, 4, input command buffer address width (depth 16).
- RD_LATENCY, 2, cycles from reg_rd pulse to reg_din valid (1..15).
- FLUSH_CYCLES, 1024, idle cycles before a partial packet is padded out.
- PAD_WORD, 32'hFFFF_FFFF, filler word.

Ports:
- clk, input, 1: single clock domain (dsp_clk).
- reset, input, 1: asynchronous, active-high; clears all state.
- rx_en, input, 1: input word strobe, no backpressure.
- rx_data, input, 32: input word.
- reg_addr, output, 16: register address.
- reg_dout, output, 32: register write data.
- reg_wr, output, 1: one-cycle write strobe.
- reg_rd, output, 1: one-cycle read strobe.
- reg_din, input, 32: read data, sampled RD_LATENCY cycles after reg_rd.
- pri_fifo_d, output, 32: reply FIFO head word (first-word-fall-through).
- pri_fifo_req, output, 1: at least PKT_WORDS words are queued.
- pri_fifo_rd, input, 1: pop the reply FIFO head.
- pri_packet_size_o, output, 9: constant PKT_WORDS.
- overflow, output, 1: sticky flag set when an input word is dropped.
- drop_count, output, 8: count of dropped input words, saturating at 255.

Behaviour:
- Reset values: all outputs 0 except pri_packet_size_o = PKT_WORDS; both FIFOs empty; FSM in IDLE; pad counters 0.
- Input buffer: push on rx_en when not full. When full, the word is dropped, overflow is set to 1 and drop_count increments (saturating). Pop is under FSM control.
- Command word format: [31] write=1/read=0; [30:24] must be 0; [23:16] tag; [15:0] address.
  - A word with [30:24] != 0 is discarded and no reply is generated.
- FSM states:
  - IDLE: if the input buffer is non-empty and the reply FIFO has >= 2 free entries, pop the word. A write goes to GET_DATA; a read goes to RD.
  - If the reply FIFO has < 2 free entries, wait (no pop).
  - GET_DATA: wait for the next buffered word, pop it as write data. Drive reg_addr/reg_dout and a one-cycle reg_wr, then go to PUSH_HDR.
  - RD: drive reg_addr and a one-cycle reg_rd; go to RD_WAIT.
  - RD_WAIT: count RD_LATENCY cycles, capture reg_din, go to PUSH_HDR.
  - PUSH_HDR: push the echoed command word with bit [30] set (ack marker); go to PUSH_DAT.
  - PUSH_DAT: push the write data or read data; return to IDLE.
- reg_addr and reg_dout hold their last value between strobes.
- wr_mod counts pushed words modulo PKT_WORDS. It wraps from PKT_WORDS-1 to 0.
- Flush timer:
  - Runs while wr_mod != 0 and the FSM is in IDLE with an empty input buffer.
  - Resets on any pushed word.
  - At FLUSH_CYCLES the FSM enters PAD.
- PAD: push PAD_WORD once per cycle until wr_mod == 0, then return to IDLE. New commands wait until PAD completes. PAD never starts when wr_mod == 0.
- pri_fifo_req = (occupancy >= PKT_WORDS). This is registered and updates the cycle after a push or pop.
- pri_fifo_d always shows the head word; it is 0 when the reply FIFO is empty.
- pri_fifo_rd while empty is ignored: no pointer movement, no error.
- Simultaneous push and pop: occupancy is unchanged; both pointers advance.
- Reset mid-operation (any state): FIFOs flushed, any pending strobe deasserted asynchronously, the partially received write is discarded, and the tag/address are not replayed.

Test Plan:
- Write then idle:
  - Stimulus: reset, then rx words 0x8005_0010 and 0xDEAD_BEEF back-to-back.
  - Required: reg_wr is a single pulse with reg_addr=0x0010 and reg_dout=0xDEADBEEF.
  - After FLUSH_CYCLES idle, the reply FIFO holds 0xC005_0010, 0xDEADBEEF, then 126 words of 0xFFFF_FFFF, and pri_fifo_req=1.
- Read latency:
  - Stimulus: rx 0x0007_0020 with reg_din=0x1234_5678 presented exactly RD_LATENCY cycles after reg_rd (other values elsewhere).
  - Required: reply words are 0x4007_0020 and 0x1234_5678.
- Full packet:
  - Stimulus: 64 back-to-back read commands.
  - Required: pri_fifo_req rises after the 128th push with no padding.
  - After the sender pops 128 words, pri_fifo_req=0 and the FIFO is empty.
- Input overflow:
  - Stimulus: hold the reply FIFO full (no pri_fifo_rd) and send 20 words.
  - Required: 16 words are buffered, overflow=1 and drop_count=4.
  - Draining the reply FIFO then processes the buffered commands in order.
- Malformed command and empty pop:
  - Stimulus: rx 0x0100_0000, then pulse pri_fifo_rd with the FIFO empty.
  - Required: no reg strobes, no reply, occupancy stays 0 and pri_fifo_d=0.
- Reset mid-write:
  - Stimulus: after the write header only, assert reset.
  - Required: reg_wr never pulses; after release, a fresh write completes normally with a correct tag.

Source files
------------

// File: rtl/config_responder.sv
// Register command endpoint: executes write/read commands from the receive path and
// queues two-word acknowledgements as fixed-size reply packets for the sender.
module config_responder #(
   parameter int unsigned PKT_WORDS    = 128,
   parameter int unsigned FIFO_AW      = 9,
   parameter int unsigned IN_AW        = 4,
   parameter int unsigned RD_LATENCY   = 2,
   parameter int unsigned FLUSH_CYCLES = 1024,
   parameter logic [31:0] PAD_WORD     = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_en,
   input  logic [31:0] rx_data,
   output logic [15:0] reg_addr,
   output logic [31:0] reg_dout,
   output logic        reg_wr,
   output logic        reg_rd,
   input  logic [31:0] reg_din,
   output logic [31:0] pri_fifo_d,
   output logic        pri_fifo_req,
   input  logic        pri_fifo_rd,
   output logic [8:0]  pri_packet_size_o,
   output logic        overflow,
   output logic [7:0]  drop_count
);
   localparam int unsigned IN_DEPTH   = 2**IN_AW;
   localparam int unsigned ICW        = IN_AW + 1;
   localparam int unsigned FIFO_DEPTH = 2**FIFO_AW;
   localparam int unsigned CW         = FIFO_AW + 1;
   localparam int unsigned MOD_W      = $clog2(PKT_WORDS);
   localparam int unsigned FL_W       = $clog2(FLUSH_CYCLES + 1);
   localparam int unsigned LAT_W      = 4;

   typedef enum logic [2:0] {IDLE, GET_DATA, RD, RD_WAIT, PUSH_HDR, PUSH_DAT, PAD} state_t;

   // input command buffer
   logic [31:0]      in_mem [IN_DEPTH];
   logic [IN_AW-1:0] in_wp, in_rp;
   logic [ICW-1:0]   in_cnt;
   logic             in_full, in_empty, in_push, in_pop_c;
   logic [31:0]      in_head;

   assign in_full  = (in_cnt == ICW'(IN_DEPTH));
   assign in_empty = (in_cnt == '0);
   assign in_push  = rx_en && !in_full;
   assign in_head  = in_mem[in_rp];

   always_ff @(posedge clk) begin
      if (in_push) in_mem[in_wp] <= rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_wp      <= '0;
         in_rp      <= '0;
         in_cnt     <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (in_push)  in_wp <= in_wp + IN_AW'(1);
         if (in_pop_c) in_rp <= in_rp + IN_AW'(1);
         in_cnt <= in_cnt + ICW'(in_push) - ICW'(in_pop_c);
         if (rx_en && in_full) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end
      end
   end

   // reply FIFO with a registered first-word-fall-through head
   logic [31:0]        rf_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] rf_wp, rf_rp, rf_rp_nxt;
   logic [CW-1:0]      rf_cnt, rf_cnt_nxt;
   logic               push_c, pop_c, rf_room2, rf_full;
   logic [31:0]        push_data_c, head_nxt;

   assign pop_c      = pri_fifo_rd && (rf_cnt != '0);
   assign rf_rp_nxt  = pop_c ? rf_rp + FIFO_AW'(1) : rf_rp;
   assign rf_cnt_nxt = rf_cnt + CW'(push_c) - CW'(pop_c);
   assign rf_room2   = (rf_cnt <= CW'(FIFO_DEPTH - 2));
   assign rf_full    = (rf_cnt == CW'(FIFO_DEPTH));

   // a word pushed into an otherwise empty FIFO becomes the head directly
   always_comb begin
      head_nxt = '0;
      if (rf_cnt_nxt != '0) begin
         if (push_c && (rf_wp == rf_rp_nxt)) head_nxt = push_data_c;
         else                                head_nxt = rf_mem[rf_rp_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) rf_mem[rf_wp] <= push_data_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wp        <= '0;
         rf_rp        <= '0;
         rf_cnt       <= '0;
         pri_fifo_d   <= '0;
         pri_fifo_req <= 1'b0;
      end else begin
         if (push_c) rf_wp <= rf_wp + FIFO_AW'(1);
         rf_rp        <= rf_rp_nxt;
         rf_cnt       <= rf_cnt_nxt;
         pri_fifo_d   <= head_nxt;
         pri_fifo_req <= (rf_cnt_nxt >= CW'(PKT_WORDS));
      end
   end

   assign pri_packet_size_o = 9'(PKT_WORDS);

   // command FSM
   state_t           state, state_nxt;
   logic [31:0]      cmd, cmd_nxt, data, data_nxt, dout_nxt;
   logic [15:0]      addr_nxt;
   logic             wr_nxt, rd_nxt;
   logic [LAT_W-1:0] lat_cnt, lat_nxt;
   logic [MOD_W-1:0] wr_mod, wr_mod_nxt;
   logic [FL_W-1:0]  flush_cnt, flush_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cmd       <= '0;
         data      <= '0;
         lat_cnt   <= '0;
         reg_addr  <= '0;
         reg_dout  <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         wr_mod    <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cmd       <= cmd_nxt;
         data      <= data_nxt;
         lat_cnt   <= lat_nxt;
         reg_addr  <= addr_nxt;
         reg_dout  <= dout_nxt;
         reg_wr    <= wr_nxt;
         reg_rd    <= rd_nxt;
         wr_mod    <= wr_mod_nxt;
         flush_cnt <= flush_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_nxt     = cmd;
      data_nxt    = data;
      lat_nxt     = lat_cnt;
      addr_nxt    = reg_addr;
      dout_nxt    = reg_dout;
      wr_nxt      = 1'b0;
      rd_nxt      = 1'b0;
      in_pop_c    = 1'b0;
      push_c      = 1'b0;
      push_data_c = '0;
      unique case (state)
         IDLE: begin
            if ((wr_mod != '0) && (flush_cnt == FL_W'(FLUSH_CYCLES))) begin
               state_nxt = PAD;
            end else if (!in_empty && rf_room2) begin
               in_pop_c = 1'b1;
               cmd_nxt  = in_head;
               if (in_head[30:24] == 7'd0) state_nxt = in_head[31] ? GET_DATA : RD;
            end
         end
         GET_DATA: begin
            if (!in_empty) begin
               in_pop_c  = 1'b1;
               data_nxt  = in_head;
               addr_nxt  = cmd[15:0];
               dout_nxt  = in_head;
               wr_nxt    = 1'b1;
               state_nxt = PUSH_HDR;
            end
         end
         RD: begin
            addr_nxt  = cmd[15:0];
            rd_nxt    = 1'b1;
            lat_nxt   = '0;
            state_nxt = RD_WAIT;
         end
         // lat_cnt is 0 in the cycle reg_rd is high
         RD_WAIT: begin
            if (lat_cnt == LAT_W'(RD_LATENCY)) begin
               data_nxt  = reg_din;
               state_nxt = PUSH_HDR;
            end else begin
               lat_nxt = lat_cnt + LAT_W'(1);
            end
         end
         PUSH_HDR: begin
            push_c      = 1'b1;
            push_data_c = cmd | 32'h4000_0000;
            state_nxt   = PUSH_DAT;
         end
         PUSH_DAT: begin
            push_c      = 1'b1;
            push_data_c = data;
            state_nxt   = IDLE;
         end
         PAD: begin
            if (wr_mod == '0) begin
               state_nxt = IDLE;
            end else if (!rf_full) begin
               push_c      = 1'b1;
               push_data_c = PAD_WORD;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // packet position and idle flush timer
   always_comb begin
      wr_mod_nxt = wr_mod;
      if (push_c) wr_mod_nxt = (wr_mod == MOD_W'(PKT_WORDS - 1)) ? '0 : wr_mod + MOD_W'(1);
      if (push_c || (state != IDLE) || !in_empty || (wr_mod == '0)) flush_nxt = '0;
      else if (flush_cnt == FL_W'(FLUSH_CYCLES))                      flush_nxt = flush_cnt;
      else                                                            flush_nxt = flush_cnt + FL_W'(1);
   end
endmodule

// File: tb/tb_config_responder.sv
// Randomized scoreboard bench for config_responder: a command-stream model predicts
// register strobes and reply words; monitors compare whatever the DUT presents.
module tb_config_responder;
   localparam int unsigned PKT   = 128;
   localparam int unsigned LAT   = 2;
   localparam int unsigned FLUSH = 1024;
   localparam logic [31:0] PAD   = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_en = 1'b0;
   logic [31:0] rx_data = '0;
   logic [15:0] reg_addr;
   logic [31:0] reg_dout;
   logic        reg_wr, reg_rd;
   logic [31:0] reg_din = '0;
   logic [31:0] pri_fifo_d;
   logic        pri_fifo_req;
   logic        pri_fifo_rd = 1'b0;
   logic [8:0]  pri_packet_size_o;
   logic        overflow;
   logic [7:0]  drop_count;

   config_responder #(.PKT_WORDS(PKT), .FIFO_AW(9), .IN_AW(4), .RD_LATENCY(LAT),
                      .FLUSH_CYCLES(FLUSH), .PAD_WORD(PAD)) dut (
      .clk(clk), .reset(reset), .rx_en(rx_en), .rx_data(rx_data),
      .reg_addr(reg_addr), .reg_dout(reg_dout), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_din(reg_din), .pri_fifo_d(pri_fifo_d), .pri_fifo_req(pri_fifo_req),
      .pri_fifo_rd(pri_fifo_rd), .pri_packet_size_o(pri_packet_size_o),
      .overflow(overflow), .drop_count(drop_count));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   logic [47:0] exp_wr_q[$];
   logic [15:0] exp_rd_q[$];
   logic [31:0] model_mem [logic [15:0]];
   logic [31:0] resp_mem  [logic [15:0]];
   int          model_mod = 0;
   bit          pend_wr = 0;
   logic [31:0] pend_cmd = '0;
   bit          sender_en = 0;
   int          burst = 0;
   bit          rd_on = 0;
   int          rd_age = 0;
   logic [15:0] rd_a = '0;

   function automatic logic [31:0] dflt(input logic [15:0] a);
      return {~a, a};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_reply(input logic [31:0] hdr, input logic [31:0] dat);
      exp_q.push_back(hdr | 32'h4000_0000);
      exp_q.push_back(dat);
      model_mod = (model_mod + 2) % PKT;
   endtask

   // command stream interpretation: header, optional data word, two-word reply
   task automatic model_word(input logic [31:0] w);
      logic [15:0] a;
      a = w[15:0];
      if (pend_wr) begin
         pend_wr = 0;
         model_mem[pend_cmd[15:0]] = w;
         exp_wr_q.push_back({pend_cmd[15:0], w});
         push_reply(pend_cmd, w);
      end else if (w[30:24] != 7'd0) begin
         pend_wr = 0;
      end else if (w[31]) begin
         pend_wr  = 1;
         pend_cmd = w;
      end else begin
         exp_rd_q.push_back(a);
         push_reply(w, model_mem.exists(a) ? model_mem[a] : dflt(a));
      end
   endtask

   task automatic model_pad();
      while (model_mod != 0) begin
         exp_q.push_back(PAD);
         model_mod = (model_mod + 1) % PKT;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_wr_q.delete();
      exp_rd_q.delete();
      model_mod = 0;
      pend_wr   = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit modelled);
      rx_en   = 1'b1;
      rx_data = w;
      @(posedge clk);
      #1;
      rx_en = 1'b0;
      if (modelled) model_word(w);
   endtask

   task automatic send_read(input logic [15:0] a, input logic [7:0] tag);
      send_word({1'b0, 7'd0, tag, a}, 1);
   endtask

   task automatic check_reset_vals();
      check("rst reg_addr", 32'(reg_addr), 32'd0);
      check("rst reg_dout", reg_dout, 32'd0);
      check("rst reg_wr", 32'(reg_wr), 32'd0);
      check("rst reg_rd", 32'(reg_rd), 32'd0);
      check("rst pri_fifo_d", pri_fifo_d, 32'd0);
      check("rst pri_fifo_req", 32'(pri_fifo_req), 32'd0);
      check("rst pkt_size", 32'(pri_packet_size_o), 32'(PKT));
      check("rst overflow", 32'(overflow), 32'd0);
      check("rst drop_count", 32'(drop_count), 32'd0);
   endtask

   // let the flush timer pad out the packet, then confirm everything drained
   task automatic idle_flush(input int extra);
      model_pad();
      idle(FLUSH + extra);
      check("reply queue drained", 32'(exp_q.size()), 32'd0);
      check("writes all seen", 32'(exp_wr_q.size()), 32'd0);
      check("reads all seen", 32'(exp_rd_q.size()), 32'd0);
      check("req after drain", 32'(pri_fifo_req), 32'd0);
      check("head when empty", pri_fifo_d, 32'd0);
   endtask

   // strobe monitor, register-file responder and packet sender
   always @(negedge clk) begin
      logic [47:0] e;
      if (reset) begin
         burst = 0;
         rd_on = 0;
      end else begin
         if (reg_wr) begin
            resp_mem[reg_addr] = reg_dout;
            if (exp_wr_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected reg_wr: addr %h data %h at %0t", reg_addr, reg_dout, $time);
            end else begin
               e = exp_wr_q.pop_front();
               check("reg_wr addr", 32'(reg_addr), 32'(e[47:32]));
               check("reg_wr data", reg_dout, e[31:0]);
            end
         end
         if (reg_rd) begin
            if (exp_rd_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected reg_rd: addr %h at %0t", reg_addr, $time);
            end else begin
               check("reg_rd addr", 32'(reg_addr), 32'(exp_rd_q.pop_front()));
            end
            rd_on  = 1;
            rd_age = 0;
            rd_a   = reg_addr;
         end
         if (rd_on && rd_age == int'(LAT)) begin
            reg_din = resp_mem.exists(rd_a) ? resp_mem[rd_a] : dflt(rd_a);
            rd_on   = 0;
         end else begin
            reg_din = $urandom;
         end
         if (rd_on) rd_age++;
         if (sender_en) begin
            pri_fifo_rd = 1'b0;
            if (burst == 0 && pri_fifo_req) burst = PKT;
            if (burst > 0) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected reply word: %h at %0t", pri_fifo_d, $time);
               end else begin
                  check("reply word", pri_fifo_d, exp_q.pop_front());
               end
               pri_fifo_rd = 1'b1;
               burst--;
            end
         end
      end
   end

   initial begin
      logic [31:0] w;
      logic [15:0] a;
      int          kind;
      model_mem[16'h0020] = 32'h1234_5678;
      resp_mem[16'h0020]  = 32'h1234_5678;
      idle(3);
      check_reset_vals();
      reset = 1'b0;
      idle(2);
      sender_en = 1;

      // write then idle: header/data echoed, then padded to a full packet
      send_word(32'h8005_0010, 1);
      send_word(32'hDEAD_BEEF, 1);
      idle_flush(500);

      // read with latency-exact read data
      send_word(32'h0007_0020, 1);
      idle_flush(500);

      // full packet of reads, no padding expected
      for (int i = 0; i < 63; i++) begin
         send_read(16'(i), 8'(i));
         idle(8);
      end
      idle(10);
      check("req at 126 words", 32'(pri_fifo_req), 32'd0);
      send_read(16'h003F, 8'h3F);
      idle_flush(500);

      // random mixed traffic with malformed words and short bursts
      for (int n = 0; n < 160; n++) begin
         kind = $urandom_range(0, 9);
         a    = 16'($urandom_range(0, 40));
         w    = $urandom;
         if (kind == 0) begin
            w[30:24] = 7'($urandom_range(1, 127));
            send_word(w, 1);
         end else if (kind < 5) begin
            send_word({1'b1, 7'd0, w[23:16], a}, 1);
            idle($urandom_range(0, 3));
            send_word($urandom, 1);
         end else begin
            send_word({1'b0, 7'd0, w[23:16], a}, 1);
         end
         if (n % 25 == 24) idle(60);
         else if (n % 25 > 19) idle(0);
         else idle($urandom_range(8, 20));
         if (n == 80) idle_flush(500);
      end
      idle_flush(500);

      // malformed command and pop while empty
      sender_en = 0;
      send_word(32'h0100_0000, 1);
      idle(20);
      pri_fifo_rd = 1'b1;
      idle(1);
      pri_fifo_rd = 1'b0;
      idle(3);
      check("empty pop head", pri_fifo_d, 32'd0);
      check("empty pop req", 32'(pri_fifo_req), 32'd0);
      sender_en = 1;
      send_word(32'h0042_0020, 1);
      idle_flush(500);

      // input overflow with the reply FIFO held full
      sender_en = 0;
      reset = 1'b1;
      model_reset();
      idle(2);
      reset = 1'b0;
      idle(2);
      for (int i = 0; i < 256; i++) begin
         send_read(16'(i), 8'(i));
         idle(8);
      end
      idle(20);
      check("req with full fifo", 32'(pri_fifo_req), 32'd1);
      for (int i = 0; i < 20; i++) send_word({1'b0, 7'd0, 8'(8'hA0 + i), 16'(16'h0100 + i)}, i < 16);
      idle(5);
      check("overflow flag", 32'(overflow), 32'd1);
      check("drop count", 32'(drop_count), 32'd4);
      sender_en = 1;
      idle_flush(1300);

      // reset in the middle of a write
      send_word(32'h80AA_0040, 0);
      idle(3);
      reset = 1'b1;
      #2;
      check_reset_vals();
      model_reset();
      idle(2);
      reset = 1'b0;
      idle(2);
      send_word(32'h80BB_0044, 1);
      send_word(32'hCAFE_F00D, 1);
      idle_flush(500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
